// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: MEM pipeline stage issuing loads/stores on a valid/ready data bus and registering the MEM->WB pipeline register
// Ports: clk/rst (async, active-low); exe_* registered EXE->MEM values; mem_stall holds the upstream pipe;
// mem_alu_result forwards the ALU result to EXE; dbus_req_*/dbus_rsp_* data bus; wb_* MEM->WB register;
// misalign_trap is the registered misalign flag. Optional macro MEM_MISALIGN_TRAP_EN enables misalign trapping.
module mem_lsu_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic [31:0]       exe_alu_result,
    input  logic [31:0]       exe_write_data,
    input  logic [4:0]        exe_rd,
    input  logic [31:0]       exe_pc_inc,
    input  logic              exe_register_write,
    input  logic [1:0]        exe_result_src,
    input  logic              exe_mem_load,
    input  logic              exe_mem_store,
    input  logic [2:0]        exe_mem_size,
    output logic              mem_stall,
    output logic [31:0]       mem_alu_result,
    output logic              dbus_req_valid,
    input  logic              dbus_req_ready,
    output logic [ADDR_W-1:0] dbus_req_addr,
    output logic              dbus_req_we,
    output logic [3:0]        dbus_req_be,
    output logic [31:0]       dbus_req_wdata,
    input  logic              dbus_rsp_valid,
    input  logic [31:0]       dbus_rsp_rdata,
    output logic              wb_valid,
    output logic              wb_register_write,
    output logic [1:0]        wb_result_src,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_alu_result,
    output logic [31:0]       wb_read_data,
    output logic [31:0]       wb_pc_inc,
    output logic              misalign_trap
);
    typedef enum logic {IDLE, WAIT_RSP} state_t;
    state_t      state_q, state_d;
    logic        memop, mis, bus_op, commit, issue;
    logic [1:0]  lo_q;
    logic [2:0]  size_q;
    logic [1:0]  sz;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [31:0] fmt;

    assign memop = exe_valid & (exe_mem_load | exe_mem_store);
    assign sz    = exe_mem_size[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = memop & (((sz == 2'b01) & exe_alu_result[0]) | ((sz == 2'b10) & (exe_alu_result[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif
    // A trapping access never reaches the bus; it commits straight away
    assign bus_op = memop & ~mis;

    always_comb begin
        state_d        = state_q;
        dbus_req_valid = 1'b0;
        mem_stall      = 1'b0;
        if (state_q == IDLE) begin
            dbus_req_valid = bus_op;
            // Stores are posted: accepted means done. Loads always wait for the response.
            mem_stall      = bus_op & (exe_mem_load | ~dbus_req_ready);
            state_d        = (bus_op & exe_mem_load & dbus_req_ready) ? WAIT_RSP : IDLE;
        end else begin
            mem_stall = ~dbus_rsp_valid;
            state_d   = dbus_rsp_valid ? IDLE : WAIT_RSP;
        end
    end

    assign issue  = (state_q == IDLE) & bus_op & exe_mem_load & dbus_req_ready;
    assign commit = exe_valid & ~mem_stall;

    assign mem_alu_result = exe_alu_result;
    assign dbus_req_addr  = {exe_alu_result[ADDR_W-1:2], 2'b00};
    assign dbus_req_we    = exe_mem_store;
    assign dbus_req_be    = ~exe_mem_store ? 4'b1111 :
                            (sz == 2'b00)  ? 4'b0001 << exe_alu_result[1:0] :
                            (sz == 2'b01)  ? 4'b0011 << {exe_alu_result[1], 1'b0} : 4'b1111;
    assign dbus_req_wdata = (sz == 2'b00) ? {4{exe_write_data[7:0]}} :
                            (sz == 2'b01) ? {2{exe_write_data[15:0]}} : exe_write_data;

    // Lane select uses the offset and size captured when the load was accepted
    assign rb  = dbus_rsp_rdata[{lo_q, 3'b000} +: 8];
    assign rh  = dbus_rsp_rdata[{lo_q[1], 4'b0000} +: 16];
    assign fmt = (size_q[1:0] == 2'b00) ? {{24{~size_q[2] & rb[7]}}, rb} :
                 (size_q[1:0] == 2'b01) ? {{16{~size_q[2] & rh[15]}}, rh} : dbus_rsp_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            lo_q              <= '0;
            size_q            <= '0;
            wb_valid          <= 1'b0;
            wb_register_write <= 1'b0;
            wb_result_src     <= '0;
            wb_rd             <= '0;
            wb_alu_result     <= '0;
            wb_read_data      <= '0;
            wb_pc_inc         <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_trap     <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            wb_valid          <= commit;
            wb_register_write <= commit & exe_register_write & ~mis;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_trap     <= commit & mis;
`endif
            if (issue) begin
                lo_q   <= exe_alu_result[1:0];
                size_q <= exe_mem_size;
            end
            if (commit) begin
                wb_result_src <= exe_result_src;
                wb_rd         <= exe_rd;
                wb_alu_result <= exe_alu_result;
                wb_pc_inc     <= exe_pc_inc;
                // Only a load completing from WAIT_RSP carries read data
                wb_read_data  <= (state_q == WAIT_RSP) ? fmt : 32'h0;
            end
        end
    end

`ifndef MEM_MISALIGN_TRAP_EN
    assign misalign_trap = 1'b0;
`endif
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb_mem_lsu_stage: self-checking bench for mem_lsu_stage (vector table + WB scoreboard + load/reset sequences)
module tb_mem_lsu_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exe_valid = 1'b0, exe_register_write = 1'b0, exe_mem_load = 1'b0, exe_mem_store = 1'b0;
    logic [31:0] exe_alu_result = '0, exe_write_data = '0, exe_pc_inc = '0;
    logic [4:0]  exe_rd = '0;
    logic [1:0]  exe_result_src = '0;
    logic [2:0]  exe_mem_size = '0;
    logic        dbus_req_ready = 1'b0, dbus_rsp_valid = 1'b0;
    logic [31:0] dbus_rsp_rdata = '0;
    logic        mem_stall, dbus_req_valid, dbus_req_we, wb_valid, wb_register_write, misalign_trap;
    logic [31:0] mem_alu_result, dbus_req_addr, dbus_req_wdata, wb_alu_result, wb_read_data, wb_pc_inc;
    logic [3:0]  dbus_req_be;
    logic [1:0]  wb_result_src;
    logic [4:0]  wb_rd;

    mem_lsu_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_alu_result(exe_alu_result),
        .exe_write_data(exe_write_data), .exe_rd(exe_rd), .exe_pc_inc(exe_pc_inc),
        .exe_register_write(exe_register_write), .exe_result_src(exe_result_src),
        .exe_mem_load(exe_mem_load), .exe_mem_store(exe_mem_store), .exe_mem_size(exe_mem_size),
        .mem_stall(mem_stall), .mem_alu_result(mem_alu_result), .dbus_req_valid(dbus_req_valid),
        .dbus_req_ready(dbus_req_ready), .dbus_req_addr(dbus_req_addr), .dbus_req_we(dbus_req_we),
        .dbus_req_be(dbus_req_be), .dbus_req_wdata(dbus_req_wdata), .dbus_rsp_valid(dbus_rsp_valid),
        .dbus_rsp_rdata(dbus_rsp_rdata), .wb_valid(wb_valid), .wb_register_write(wb_register_write),
        .wb_result_src(wb_result_src), .wb_rd(wb_rd), .wb_alu_result(wb_alu_result),
        .wb_read_data(wb_read_data), .wb_pc_inc(wb_pc_inc), .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu, rdata, pc;
        logic        rw;
        logic [1:0]  src;
        logic        trap;
    } wb_t;

    typedef struct {
        logic [31:0] a, d;
        logic [4:0]  rd;
        logic [2:0]  sz;
        logic        st;
        logic [3:0]  be;
        logic [31:0] wd;
    } vec_t;

    wb_t         sb[$];
    vec_t        vt[7];
    int          checks = 0, errors = 0, req_cnt = 0, r0;
    logic [31:0] pc = 32'h1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic st, input logic [2:0] sz);
        exe_valid          = 1'b1;
        exe_alu_result     = a;
        exe_write_data     = d;
        exe_rd             = rd;
        exe_register_write = rw;
        exe_mem_load       = ld;
        exe_mem_store      = st;
        exe_mem_size       = sz;
        exe_result_src     = ld ? 2'b01 : 2'b00;
        pc                 = pc + 32'd4;
        exe_pc_inc         = pc;
    endtask

    task automatic expect_wb(input logic [31:0] rdata, input logic rw, input logic trap);
        wb_t e;
        e.rd    = exe_rd;
        e.alu   = exe_alu_result;
        e.rdata = rdata;
        e.pc    = exe_pc_inc;
        e.rw    = rw;
        e.src   = exe_result_src;
        e.trap  = trap;
        sb.push_back(e);
    endtask

    task automatic load_seq(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] rdata,
                            input logic [31:0] exp, input int wr, input int ws);
        drive(a, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, sz);
        expect_wb(exp, 1'b1, 1'b0);
        for (int i = 0; i < wr; i++) begin
            dbus_req_ready = 1'b0;
            #1;
            chk("ld_norady_stall", 32'(mem_stall), 32'd1);
            chk("ld_norady_valid", 32'(dbus_req_valid), 32'd1);
            chk("ld_norady_addr", dbus_req_addr, a & ~32'h3);
            tick();
        end
        dbus_req_ready = 1'b1;
        #1;
        chk("ld_issue_stall", 32'(mem_stall), 32'd1);
        chk("ld_issue_valid", 32'(dbus_req_valid), 32'd1);
        chk("ld_issue_addr", dbus_req_addr, a & ~32'h3);
        chk("ld_issue_be_we", {27'd0, dbus_req_be, dbus_req_we}, {27'd0, 4'b1111, 1'b0});
        tick();
        dbus_req_ready = 1'b0;
        for (int i = 0; i < ws; i++) begin
            #1;
            chk("ld_wait_stall", 32'(mem_stall), 32'd1);
            chk("ld_wait_novalid", 32'(dbus_req_valid), 32'd0);
            tick();
        end
        dbus_rsp_valid = 1'b1;
        dbus_rsp_rdata = rdata;
        #1;
        chk("ld_rsp_stall", 32'(mem_stall), 32'd0);
        tick();
        dbus_rsp_valid = 1'b0;
        dbus_rsp_rdata = '0;
        exe_valid      = 1'b0;
    endtask

    always @(posedge clk) if (rst && dbus_req_valid && dbus_req_ready) req_cnt++;

    always @(negedge clk) begin
        if (rst && wb_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got commit rd %0d alu %h expected none", wb_rd, wb_alu_result);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_alu_result", wb_alu_result, e.alu);
                chk("wb_read_data", wb_read_data, e.rdata);
                chk("wb_pc_inc", wb_pc_inc, e.pc);
                chk("wb_rw_src_trap", {28'd0, wb_register_write, wb_result_src, misalign_trap}, {28'd0, e.rw, e.src, e.trap});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{32'h0000_1234, 32'h0,          5'd5,  3'b000, 1'b0, 4'b0000, 32'h0};
        vt[1] = '{32'h0000_0103, 32'hAABB_CCDD, 5'd0,  3'b000, 1'b1, 4'b1000, 32'hDDDD_DDDD};
        vt[2] = '{32'h0000_0102, 32'h1122_3344, 5'd0,  3'b001, 1'b1, 4'b1100, 32'h3344_3344};
        vt[3] = '{32'h0000_0100, 32'h1122_3344, 5'd0,  3'b001, 1'b1, 4'b0011, 32'h3344_3344};
        vt[4] = '{32'h0000_0104, 32'hDEAD_BEEF, 5'd0,  3'b010, 1'b1, 4'b1111, 32'hDEAD_BEEF};
        vt[5] = '{32'h0000_0100, 32'h0000_00A5, 5'd0,  3'b000, 1'b1, 4'b0001, 32'hA5A5_A5A5};
        vt[6] = '{32'hFFFF_FFFF, 32'h0,          5'd31, 3'b000, 1'b0, 4'b0000, 32'h0};

        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_ctrl", {26'd0, wb_register_write, wb_result_src, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_alu_result | wb_read_data | wb_pc_inc, 32'd0);
        chk("rst_trap", 32'(misalign_trap), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vt[i].a, vt[i].d, vt[i].rd, ~vt[i].st, 1'b0, vt[i].st, vt[i].sz);
            dbus_req_ready = 1'b1;
            #1;
            expect_wb(32'h0, ~vt[i].st, 1'b0);
            chk("tv_stall", 32'(mem_stall), 32'd0);
            chk("tv_req_valid", 32'(dbus_req_valid), 32'(vt[i].st));
            chk("tv_fwd", mem_alu_result, vt[i].a);
            if (vt[i].st) begin
                chk("tv_addr", dbus_req_addr, vt[i].a & ~32'h3);
                chk("tv_be_we", {27'd0, dbus_req_be, dbus_req_we}, {27'd0, vt[i].be, 1'b1});
                chk("tv_wdata", dbus_req_wdata, vt[i].wd);
            end
            tick();
        end
        exe_valid = 1'b0;
        dbus_req_ready = 1'b0;
        tick();

        load_seq(32'h0000_0202, 3'b000, 32'h0080_0000, 32'hFFFF_FF80, 2, 2);
        load_seq(32'h0000_0202, 3'b100, 32'h0080_0000, 32'h0000_0080, 2, 2);
        load_seq(32'h0000_0302, 3'b101, 32'h8001_7FFF, 32'h0000_8001, 0, 1);
        load_seq(32'h0000_0302, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001, 1, 0);
        load_seq(32'h0000_0201, 3'b000, 32'h1234_7F56, 32'h0000_007F, 0, 0);

        r0 = req_cnt;
        load_seq(32'h0000_0500, 3'b010, 32'h1234_5678, 32'h1234_5678, 0, 0);
        drive(32'h0000_0504, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
        expect_wb(32'h0, 1'b0, 1'b0);
        dbus_req_ready = 1'b0;
        #1;
        chk("st_norady_stall", 32'(mem_stall), 32'd1);
        tick();
        dbus_req_ready = 1'b1;
        #1;
        chk("st_rady_stall", 32'(mem_stall), 32'd0);
        tick();
        exe_valid = 1'b0;
        dbus_req_ready = 1'b0;
        chk("b2b_req_count", 32'(req_cnt - r0), 32'd2);
        tick();

`ifdef MEM_MISALIGN_TRAP_EN
        drive(32'h0000_0401, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
        dbus_req_ready = 1'b1;
        #1;
        expect_wb(32'h0, 1'b0, 1'b1);
        chk("mis_req_valid", 32'(dbus_req_valid), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        tick();
        exe_valid = 1'b0;
        dbus_req_ready = 1'b0;
        chk("mis_trap", 32'(misalign_trap), 32'd1);
        tick();
        chk("mis_trap_clear", 32'(misalign_trap), 32'd0);
`else
        load_seq(32'h0000_0401, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0);
        chk("nomis_trap", 32'(misalign_trap), 32'd0);
`endif
        tick();
        tick();

        drive(32'h0000_0600, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
        dbus_req_ready = 1'b1;
        #1;
        tick();
        exe_valid = 1'b0;
        dbus_req_ready = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("mrst_wb_ctrl", {26'd0, wb_register_write, wb_result_src, wb_rd}, 32'd0);
        chk("mrst_wb_data", wb_alu_result | wb_read_data | wb_pc_inc, 32'd0);
        chk("mrst_trap", 32'(misalign_trap), 32'd0);
        tick();
        rst = 1'b1;
        drive(32'h0000_0055, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000);
        dbus_rsp_valid = 1'b1;
        dbus_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        expect_wb(32'h0, 1'b1, 1'b0);
        chk("late_rsp_stall", 32'(mem_stall), 32'd0);
        chk("late_rsp_req", 32'(dbus_req_valid), 32'd0);
        tick();
        dbus_rsp_valid = 1'b0;
        exe_valid = 1'b0;
        tick();
        tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- MEM pipeline stage, directly downstream of the ALU/execute stage.
- Consumes the registered EXE→MEM values: ALU result/address, store data, rd, pc_inc and control bits.
- Performs loads/stores over a valid/ready data bus, with byte-enable generation and load alignment/extension.
- Stalls the pipe while a bus access is outstanding and registers results into the MEM→WB pipeline register.

Parameters:
- ADDR_W, 32, data-bus address width; exe_alu_result[ADDR_W-1:0] is used as the address.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- exe_valid  in  1  MEM stage holds a valid instruction
- exe_alu_result  in  32  ALU result / effective address
- exe_write_data  in  32  store data (already forwarded)
- exe_rd  in  5  destination register
- exe_pc_inc  in  32  PC+4
- exe_register_write  in  1  instruction writes rd
- exe_result_src  in  2  WB mux select (passed through)
- exe_mem_load  in  1  load instruction
- exe_mem_store  in  1  store instruction
- exe_mem_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_stall  out  1  hold IF/ID/EXE and the EXE→MEM register
- mem_alu_result  out  32  forwarding value to EXE (= exe_alu_result, combinational)
- dbus_req_valid  out  1  request valid
- dbus_req_ready  in  1  request accepted
- dbus_req_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dbus_req_we  out  1  1 = store
- dbus_req_be  out  4  byte enables
- dbus_req_wdata  out  32  lane-replicated store data
- dbus_rsp_valid  in  1  load data valid
- dbus_rsp_rdata  in  32  load word
- wb_valid, wb_register_write  out  1 each  MEM→WB control
- wb_result_src  out  2  MEM→WB control
- wb_rd  out  5  MEM→WB control
- wb_alu_result, wb_read_data, wb_pc_inc  out  32 each  MEM→WB data
- misalign_trap  out  1  registered misalign flag to WB; tied 0 without the macro

Behaviour:
- memop = exe_valid & (exe_mem_load | exe_mem_store).
- FSM states: IDLE, WAIT_RSP. Reset (rst=0) forces IDLE immediately.
- Reset values: all wb_* outputs 0 and misalign_trap 0.
- IDLE:
  - dbus_req_valid = memop.
  - Store with ready: commit this cycle; mem_stall=0; stay IDLE (posted write).
  - Load with ready: go to WAIT_RSP; mem_stall=1.
  - memop without ready: stay IDLE; mem_stall=1; request fields stay stable.
  - Non-memop: mem_stall=0; commit pass-through.
- WAIT_RSP:
  - dbus_req_valid=0; mem_stall=1 until dbus_rsp_valid.
  - On dbus_rsp_valid: commit with formatted data; mem_stall=0; go to IDLE.
- dbus_rsp_valid in IDLE is ignored. This also covers a response arriving after a mid-access reset.
- Latency: ALU op 0 stall cycles; store ≥0 stall cycles (0 if ready is high); load ≥1 stall cycle.
- Commit = exe_valid & ~mem_stall.
  - On commit, the WB register captures all fields and sets wb_valid=1.
  - On a stalled or invalid cycle, wb_valid<=0 and wb_register_write<=0 (bubble); data fields are don't-care.
- Store byte enables:
  - SB: be = 4'b0001<<a[1:0]; wdata = {4{d[7:0]}}.
  - SH: be = 4'b0011<<{a[1],1'b0}; wdata = {2{d[15:0]}}.
  - SW: be = 4'b1111; wdata = d.
  - Loads drive be=4'b1111 and we=0.
- Load format, selected by address low bits latched at issue:
  - LB/LBU: byte a[1:0], sign- or zero-extended to 32.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: full word.
  - The result goes to wb_read_data; wb_read_data=0 for non-loads.
- Without the macro, misaligned accesses ignore the offending low address bits (H ignores a[0]; W ignores a[1:0]).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - H with a[0]=1, or W with a[1:0]≠0, issues no bus request (dbus_req_valid=0) and no stall.
  - The access commits immediately with misalign_trap=1, wb_register_write=0, wb_valid=1, for one cycle.
- Undefined: misalign_trap constant 0; behaviour as in Behaviour.

Test Plan:
- Reset: rst=0 while in WAIT_RSP, then release → state IDLE, all wb_* 0, a late dbus_rsp_valid=1 is ignored, mem_stall=0 for the next ALU op.
- ALU pass-through: add result 0x0000_1234, rd=5, no memop → mem_stall never 1; next cycle wb_alu_result=0x1234, wb_rd=5, wb_valid=1.
- SB addr 0x103, data 0xAABBCCDD, ready=1 → same cycle req_valid=1, addr=0x100, be=4'b1000, wdata=0xDDDDDDDD, mem_stall=0.
- LB addr 0x202, ready held 0 for 2 cycles, rdata=0x0080_0000 after 3 more cycles → mem_stall=1 throughout, req fields stable; wb_read_data=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- LHU addr 0x302, rdata=0x8001_7FFF → 0x0000_8001; LW back-to-back with a store → each commits exactly once, no duplicate bus requests.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x401 → no dbus_req_valid, mem_stall=0, next cycle misalign_trap=1, wb_register_write=0. Without the macro: bus addr=0x400, be=4'b1111.
